// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the ALU control payload used by decode and execute.
package riscv_pkg;

    localparam int unsigned ILEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned F3_W   = 3;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
    localparam logic [F3_W-1:0] F3_SL   = 3'b001;
    localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
    localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
    localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
    localparam logic [F3_W-1:0] F3_SR   = 3'b101;
    localparam logic [F3_W-1:0] F3_OR   = 3'b110;
    localparam logic [F3_W-1:0] F3_AND  = 3'b111;

    typedef struct packed {
        logic [F3_W-1:0]   funct3;
        logic              invert;
        logic              reg_write;
        logic              illegal;
        logic [REG_AW-1:0] rd;
    } alu_ctrl_t;

    typedef enum logic [1:0] {OP1_ZERO, OP1_RS1, OP1_PC} op1_sel_e;
    typedef enum logic [1:0] {OP2_ZERO, OP2_RS2, OP2_IMM} op2_sel_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational decode of ALU-class instructions into control, immediate and operand selects.
module alu_decoder
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [ILEN-1:0] instr,
    output alu_ctrl_t       ctrl_c,
    output logic [XLEN-1:0] imm_c,
    output op1_sel_e        op1_sel_c,
    output op2_sel_e        op2_sel_c
);

    logic [6:0]      opcode;
    logic [F3_W-1:0] f3;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic            shamt_ok;
    logic            alt_ok;

    assign opcode   = instr[6:0];
    assign f3       = instr[14:12];
    assign imm_i    = XLEN'($signed(instr[31:20]));
    assign imm_u    = XLEN'($signed({instr[31:12], 12'b0}));
    assign shamt    = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
    // Bit 25 is part of shamt only on RV64.
    assign shamt_ok = (XLEN == 64) || !instr[25];
    assign alt_ok   = (f3 == F3_ADD) || (f3 == F3_SR);

    logic            legal;
    logic            inv;
    logic [XLEN-1:0] imm;
    op1_sel_e        op1_sel;
    op2_sel_e        op2_sel;

    always_comb begin
        legal   = 1'b0;
        inv     = 1'b0;
        imm     = '0;
        op1_sel = OP1_ZERO;
        op2_sel = OP2_ZERO;
        unique case (opcode)
            OPC_OP: begin
                op1_sel = OP1_RS1;
                op2_sel = OP2_RS2;
                legal   = (instr[31:25] == 7'b0000000) ||
                          (alt_ok && instr[31:25] == 7'b0100000);
                inv     = alt_ok && instr[30];
            end
            OPC_OP_IMM: begin
                op1_sel = OP1_RS1;
                op2_sel = OP2_IMM;
                if (f3 == F3_SL) begin
                    imm   = shamt;
                    legal = shamt_ok && (instr[31:26] == 6'b000000);
                end else if (f3 == F3_SR) begin
                    imm   = shamt;
                    inv   = instr[30];
                    legal = shamt_ok && ((instr[31:26] == 6'b000000) ||
                                         (instr[31:26] == 6'b010000));
                end else begin
                    imm   = imm_i;
                    legal = 1'b1;
                end
            end
            OPC_LUI: begin
                op2_sel = OP2_IMM;
                imm     = imm_u;
                legal   = 1'b1;
            end
            OPC_AUIPC: begin
                op1_sel = OP1_PC;
                op2_sel = OP2_IMM;
                imm     = imm_u;
                legal   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal encodings go to the trap path with neutral control and zero operands.
    always_comb begin
        ctrl_c           = '0;
        ctrl_c.rd        = instr[11:7];
        ctrl_c.reg_write = legal;
        ctrl_c.illegal   = !legal;
        imm_c            = '0;
        op1_sel_c        = OP1_ZERO;
        op2_sel_c        = OP2_ZERO;
        if (legal) begin
            ctrl_c.funct3 = (opcode == OPC_OP || opcode == OPC_OP_IMM) ? f3 : F3_ADD;
            ctrl_c.invert = inv;
            imm_c         = imm;
            op1_sel_c     = op1_sel;
            op2_sel_c     = op2_sel;
        end
    end

endmodule

// File: rtl/alu_decode_stage.sv
// ALU decode stage: decode, operand select and a single registered slot toward execute.
module alu_decode_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ILEN-1:0]   instr,
    input  logic [XLEN-1:0]   pc,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [F3_W-1:0]   alu_funct3,
    output logic              alu_invert,
    output logic [XLEN-1:0]   operand_1,
    output logic [XLEN-1:0]   operand_2,
    output logic [REG_AW-1:0] rd,
    output logic              reg_write,
    output logic              illegal
);

    alu_ctrl_t       dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    op1_sel_e        op1_sel;
    op2_sel_e        op2_sel;
    logic [XLEN-1:0] op1_next;
    logic [XLEN-1:0] op2_next;
    logic            accept;
    alu_ctrl_t       ctrl_q;

    alu_decoder #(.XLEN(XLEN)) u_decoder (
        .instr     (instr),
        .ctrl_c    (dec_ctrl),
        .imm_c     (dec_imm),
        .op1_sel_c (op1_sel),
        .op2_sel_c (op2_sel)
    );

    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign in_ready = !out_valid || out_ready || flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        op1_next = '0;
        op2_next = '0;
        unique case (op1_sel)
            OP1_RS1: op1_next = rs1_data;
            OP1_PC:  op1_next = pc;
            default: op1_next = '0;
        endcase
        unique case (op2_sel)
            OP2_RS2: op2_next = rs2_data;
            OP2_IMM: op2_next = dec_imm;
            default: op2_next = '0;
        endcase
    end

    // Flush wins over accept and drain; a flushed offer is consumed but never loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
            operand_1 <= '0;
            operand_2 <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && !flush) begin
                ctrl_q    <= dec_ctrl;
                operand_1 <= op1_next;
                operand_2 <= op2_next;
            end
        end
    end

    assign alu_funct3 = ctrl_q.funct3;
    assign alu_invert = ctrl_q.invert;
    assign rd         = ctrl_q.rd;
    assign reg_write  = ctrl_q.reg_write;
    assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed self-checking bench for alu_decode_stage (XLEN=32).
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_funct3;
    logic        alu_invert;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;

    int n_checks = 0;
    int n_pass   = 0;

    alu_decode_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .pc         (pc),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_funct3 (alu_funct3),
        .alu_invert (alu_invert),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .rd         (rd),
        .reg_write  (reg_write),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] p);
        in_valid = 1'b1;
        instr    = i;
        rs1_data = r1;
        rs2_data = r2;
        pc       = p;
    endtask

    task automatic check_slot(input string tag, input logic [2:0] f3, input logic inv,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic [4:0] exp_rd, input logic rw, input logic ill);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".funct3"}, 64'(alu_funct3), 64'(f3));
        check({tag, ".invert"}, 64'(alu_invert), 64'(inv));
        check({tag, ".op1"}, 64'(operand_1), 64'(op1));
        check({tag, ".op2"}, 64'(operand_2), 64'(op2));
        check({tag, ".rd"}, 64'(rd), 64'(exp_rd));
        check({tag, ".reg_write"}, 64'(reg_write), 64'(rw));
        check({tag, ".illegal"}, 64'(illegal), 64'(ill));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 64'(out_valid), 64'd0);
        check({tag, ".funct3"}, 64'(alu_funct3), 64'd0);
        check({tag, ".invert"}, 64'(alu_invert), 64'd0);
        check({tag, ".op1"}, 64'(operand_1), 64'd0);
        check({tag, ".op2"}, 64'(operand_2), 64'd0);
        check({tag, ".rd"}, 64'(rd), 64'd0);
        check({tag, ".reg_write"}, 64'(reg_write), 64'd0);
        check({tag, ".illegal"}, 64'(illegal), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
        step();
        step();
        check_zero("reset");
        rst = 1'b0;
        #1;
        check("reset.in_ready", 64'(in_ready), 64'd1);

        // ADDI x1, x0, 5
        offer(32'h0050_0093, 32'd0, 32'd0, 32'd0);
        #1;
        check("addi.rs1_addr", 64'(rs1_addr), 64'd0);
        check("addi.rs2_addr", 64'(rs2_addr), 64'd5);
        step();
        check_slot("addi", 3'b000, 1'b0, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0);

        // SUB x3, x1, x2, back to back with no bubble
        offer(32'h4020_81B3, 32'd10, 32'd3, 32'd0);
        #1;
        check("sub.rs1_addr", 64'(rs1_addr), 64'd1);
        check("sub.rs2_addr", 64'(rs2_addr), 64'd2);
        step();
        check_slot("sub", 3'b000, 1'b1, 32'd10, 32'd3, 5'd3, 1'b1, 1'b0);

        // SRAI x5, x6, 3
        offer(32'h4033_5293, 32'h80, 32'hDEAD, 32'd0);
        step();
        check_slot("srai", 3'b101, 1'b1, 32'h80, 32'd3, 5'd5, 1'b1, 1'b0);

        // SLLI with instr[25] set is illegal on RV32
        offer(32'h0220_9093, 32'h1234, 32'h5678, 32'd0);
        step();
        check_slot("slli25", 3'b000, 1'b0, 32'd0, 32'd0, 5'd1, 1'b0, 1'b1);

        // LUI x7, 0x12345
        offer(32'h1234_53B7, 32'hFFFF, 32'hFFFF, 32'h100);
        step();
        check_slot("lui", 3'b000, 1'b0, 32'd0, 32'h1234_5000, 5'd7, 1'b1, 1'b0);

        // AUIPC x7, 0x12345 at pc 0x100
        offer(32'h1234_5397, 32'hFFFF, 32'hFFFF, 32'h100);
        step();
        check_slot("auipc", 3'b000, 1'b0, 32'h100, 32'h1234_5000, 5'd7, 1'b1, 1'b0);

        // ADDI x2, x0, -1: sign-extended immediate
        offer(32'hFFF0_0113, 32'd0, 32'd0, 32'd0);
        step();
        check_slot("addi_neg", 3'b000, 1'b0, 32'd0, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b0);

        // LW x5, 0(x2): not ALU-class
        offer(32'h0001_2283, 32'h77, 32'h88, 32'd0);
        step();
        check_slot("load", 3'b000, 1'b0, 32'd0, 32'd0, 5'd5, 1'b0, 1'b1);

        // SLL with funct7 0100000 is malformed
        offer(32'h4020_91B3, 32'h77, 32'h88, 32'd0);
        step();
        check_slot("sll_f7", 3'b000, 1'b0, 32'd0, 32'd0, 5'd3, 1'b0, 1'b1);

        // SRLI with instr[31:26]=010000 and shamt 1 is legal, invert follows bit 30
        offer(32'h4011_5213, 32'h40, 32'd0, 32'd0);
        step();
        check_slot("srai1", 3'b101, 1'b1, 32'h40, 32'd1, 5'd4, 1'b1, 1'b0);

        // Stall: A held while B is offered for 3 cycles
        offer(32'h0050_0093, 32'd0, 32'd0, 32'd0);
        step();
        out_ready = 1'b0;
        offer(32'h0070_0113, 32'd0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall.in_ready", 64'(in_ready), 64'd0);
            rs1_data = 32'(i + 100);
            step();
            check_slot("stall", 3'b000, 1'b0, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        check("unstall.in_ready", 64'(in_ready), 64'd1);
        rs1_data = 32'd0;
        step();
        check_slot("unstall", 3'b000, 1'b0, 32'd0, 32'd7, 5'd2, 1'b1, 1'b0);
        in_valid = 1'b0;
        step();
        check("drain.valid", 64'(out_valid), 64'd0);

        // Flush with an instruction offered: it is dropped
        offer(32'h0090_0193, 32'd0, 32'd0, 32'd0);
        flush = 1'b1;
        #1;
        check("flush.in_ready", 64'(in_ready), 64'd1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush.valid", 64'(out_valid), 64'd0);
        step();
        check("flush_after.valid", 64'(out_valid), 64'd0);

        // Flush during a stall discards the held slot
        offer(32'h0050_0093, 32'd0, 32'd0, 32'd0);
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        check("flush_stall.valid", 64'(out_valid), 64'd0);

        // Reset mid-stall, together with flush
        offer(32'h4020_81B3, 32'd10, 32'd3, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        step();
        check("pre_reset.valid", 64'(out_valid), 64'd1);
        rst   = 1'b1;
        flush = 1'b1;
        step();
        check_zero("mid_reset");
        rst   = 1'b0;
        flush = 1'b0;
        #1;
        check("post_reset.in_ready", 64'(in_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Decode stage feeding the integer ALU. It accepts one 32-bit instruction per handshake from fetch and decodes the ALU-class opcodes (OP, OP-IMM, LUI, AUIPC) into `funct3`, `invert` and two operands. Register-file operands are captured in the same cycle, and the result sits in a single registered slot with a valid/ready handshake toward execute. It is the producer side of the ALU control interface.

## Interface
- `XLEN`, default 32: datapath width; only 32 or 64 are legal.
- `clk` in, 1 bit: clock, rising edge.
- `rst` in, 1 bit: synchronous, active-high reset.
- `flush` in, 1 bit: discards the held slot and any instruction offered in the same cycle.
- `in_valid` in, 1 bit: fetch presents an instruction.
- `in_ready` out, 1 bit: stage can accept an instruction.
- `instr` in, 32 bits: instruction word.
- `pc` in, XLEN bits: address of `instr`.
- `rs1_addr` out, 5 bits: combinational, equals `instr[19:15]`.
- `rs2_addr` out, 5 bits: combinational, equals `instr[24:20]`.
- `rs1_data`, `rs2_data` in, XLEN bits each: combinational register-file read data.
- `out_valid` out, 1 bit: decoded slot is valid.
- `out_ready` in, 1 bit: execute accepts the slot.
- `alu_funct3` out, 3 bits: ALU operation select.
- `alu_invert` out, 1 bit: SUB / arithmetic-shift select.
- `operand_1`, `operand_2` out, XLEN bits each.
- `rd` out, 5 bits: destination register.
- `reg_write` out, 1 bit: write-back enable.
- `illegal` out, 1 bit: instruction is not ALU-class or is malformed.

## Operation
- Accept condition: `in_valid && in_ready`. `in_ready = !out_valid || out_ready || flush`.
- **OP (0110011):**
  - `funct3 = instr[14:12]`, `op1 = rs1_data`, `op2 = rs2_data`.
  - `invert = instr[30]` when funct3 is 000 or 101.
  - `funct7` must be 0000000, or 0100000 for funct3 000/101; any other value is illegal.
- **OP-IMM (0010011):**
  - `op2` is the sign-extended `imm_i`; `op1 = rs1_data`.
  - `invert = 0`, except for funct3 101 where `invert = instr[30]`.
  - For shifts (funct3 001/101), `op2` is the zero-extended shamt.
  - When XLEN=32, `instr[25]=1` is illegal.
  - SLLI requires `instr[31:26]` to be zero.
  - SRLI/SRAI require `instr[31:26]` to be 000000 or 010000.
- **LUI (0110111):** `funct3 = 000`, `op1 = 0`, `op2 = {instr[31:12], 12'b0}` sign-extended to XLEN.
- **AUIPC (0010111):** as LUI, but `op1 = pc`.
- **Any other opcode, or a malformed encoding:**
  - `illegal = 1`, `reg_write = 0`, `funct3 = 000`, `invert = 0`.
  - Both operands are 0.
  - `rd = instr[11:7]`.
  - The slot still goes valid, so the trap path sees it.
- Legal instructions give `reg_write = 1` and `rd = instr[11:7]`. `rd = 0` still asserts `reg_write`, because the register file ignores x0.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N is on the outputs after edge N with `out_valid = 1`.
- Throughput is 1 per cycle while `out_ready = 1`.
- **Stall:** `out_valid && !out_ready` holds every output stable and drops `in_ready` to 0. `rs1_data`/`rs2_data` are sampled only at the accepting edge.
- **Simultaneous drain and accept:** the slot is replaced at the same edge with no bubble.
- **Flush:** `out_valid` is 0 after the edge, and an instruction offered in the same cycle is consumed and dropped. Flush overrides accept and `out_ready`.
- **Reset:**
  - Every registered output clears to 0: `out_valid`, `alu_funct3`, `alu_invert`, `operand_1`, `operand_2`, `rd`, `reg_write`, `illegal`.
  - `in_ready` reads 1 once reset deasserts.
  - Reset mid-stall discards the held slot.
  - Reset has priority over flush.
- Data registers load only on accept. They need not clear on flush, but must read 0 after reset.

## Structure
- Shared package `riscv_pkg` holds:
  - opcode constants (`OPC_OP`, `OPC_OP_IMM`, `OPC_LUI`, `OPC_AUIPC`);
  - the funct3 constants `F3_ADD`, `F3_SL`, `F3_SLT`, `F3_SLTU`, `F3_XOR`, `F3_SR`, `F3_OR`, `F3_AND`, moved so that both this stage and the ALU use them;
  - a packed struct `alu_ctrl_t` with fields `{funct3, invert, reg_write, illegal, rd}`.
- One combinational sub-module `alu_decoder` maps `instr` to `alu_ctrl_t` plus the immediate and operand-select signals. The top level holds the operand mux, the slot register and the handshake.

## Test plan
- **ADDI:** `instr = 0x00500093`, `rs1_data = 0` → next cycle `funct3 = 000`, `invert = 0`, `op1 = 0`, `op2 = 5`, `rd = 1`, `reg_write = 1`, `illegal = 0`.
- **SUB:** `instr = 0x402081B3`, `rs1_data = 10`, `rs2_data = 3` → `funct3 = 000`, `invert = 1`, `op1 = 10`, `op2 = 3`, `rd = 3`.
- **SRAI:** `instr = 0x40335293` → `funct3 = 101`, `invert = 1`, `op2 = 3`, `rd = 5`.
- **SLLI with `instr[25] = 1` (XLEN=32):** → `illegal = 1`, `reg_write = 0`.
- **LUI / AUIPC:** LUI `instr = 0x123453B7` → `op1 = 0`, `op2 = 0x12345000`, `rd = 7`. The same word with opcode 0010111 and `pc = 0x100` → `op1 = 0x100`.
- **Stall:** hold `out_ready = 0` for 3 cycles with `in_valid = 1` → outputs frozen and `in_ready = 0`. Raise `out_ready` → the next instruction appears on the following cycle with no bubble.
- **Flush:** assert `flush` with `in_valid = 1` → `out_valid = 0` next cycle and that instruction never appears.
- **Reset mid-stall:** assert `rst` during a stall → all outputs 0 next cycle.
